a0_uart_logger: RTL

Downstream observer of the single-cycle `cpu`: watches the core's `a0_output` register-file tap, queues every change of value, and serialises each queued word over a UART 8N1 transmit line. It is the bench and FPGA-board debug path for program results. It never stalls or back-pressures the core.

---
 rtl/a0_uart_logger.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/a0_uart_logger.sv
// Observes the core's a0 tap, queues every change of value and serialises each
// queued word MSB-byte first over a UART 8N1 transmit line.
module a0_uart_logger #(
    parameter int WIDTH        = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              a0_in,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int NB = WIDTH / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
    localparam logic [BW-1:0] BYTE_ONE  = BW'(1);
    localparam logic [BW-1:0] BYTE_ZERO = BW'(0);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   PTR_ZERO  = (AW+1)'(0);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [LW-1:0] LVL_ZERO  = LW'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [WIDTH-1:0] a0_q_r;
    logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             overflow_r;
    logic             busy_r;
    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [BW-1:0]    byte_idx_r;
    logic [2:0]       bit_idx_r;
    logic [CW-1:0]    cnt_r;
    logic             tx_r;

    logic             empty_s;
    logic             full_s;
    logic             push_req_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             cnt_done_s;
    logic             active_next_s;
    logic [LW-1:0]    level_next_s;
    logic [7:0]       cur_byte_s;

    // FIFO status, push/pop arbitration and next-cycle activity
    always_comb begin
        empty_s       = (wr_ptr_r == rd_ptr_r);
        full_s        = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        push_req_s    = (a0_in != a0_q_r);
        pop_s         = (state_r == IDLE) && !empty_s;
        // A pop in the same cycle frees the slot a full FIFO needs.
        push_s        = push_req_s && (!full_s || pop_s);
        drop_s        = push_req_s && full_s && !pop_s;
        cnt_done_s    = (cnt_r == CNT_LAST);
        cur_byte_s    = shreg_r[WIDTH-1 -: 8];
        level_next_s  = level_r;
        active_next_s = 1'b1;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_ONE;
            2'b01:   level_next_s = level_r - LVL_ONE;
            default: level_next_s = level_r;
        endcase
        case (state_r)
            IDLE:    active_next_s = pop_s;
            STOP:    active_next_s = !(cnt_done_s && (byte_idx_r == BYTE_LAST));
            default: active_next_s = 1'b1;
        endcase
    end

    // Change-detect register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a0_q_r <= {WIDTH{1'b0}};
        end else begin
            a0_q_r <= a0_in;
        end
    end

    // FIFO storage; contents are meaningless while the pointers say empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= a0_in;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            level_r    <= LVL_ZERO;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            level_r <= level_next_s;
            busy_r  <= active_next_s || (level_next_s != LVL_ZERO);
        end
    end

    // Transmit FSM: start bit, 8 data bits LSB first, stop bit, per byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            shreg_r    <= {WIDTH{1'b0}};
            byte_idx_r <= BYTE_ZERO;
            bit_idx_r  <= 3'd0;
            cnt_r      <= CNT_ZERO;
            tx_r       <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r  <= 1'b1;
                    cnt_r <= CNT_ZERO;
                    if (pop_s) begin
                        shreg_r    <= mem_r[rd_ptr_r[AW-1:0]];
                        byte_idx_r <= BYTE_ZERO;
                        tx_r       <= 1'b0;
                        state_r    <= START;
                    end
                end
                START: begin
                    if (cnt_done_s) begin
                        cnt_r     <= CNT_ZERO;
                        bit_idx_r <= 3'd0;
                        tx_r      <= cur_byte_s[0];
                        state_r   <= DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_done_s) begin
                        cnt_r <= CNT_ZERO;
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= cur_byte_s[bit_idx_r + 3'd1];
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_done_s) begin
                        cnt_r <= CNT_ZERO;
                        if (byte_idx_r == BYTE_LAST) begin
                            state_r <= IDLE;
                        end else begin
                            // Next byte moves into the top slot; no gap before its start bit.
                            byte_idx_r <= byte_idx_r + BYTE_ONE;
                            shreg_r    <= shreg_r << 8;
                            tx_r       <= 1'b0;
                            state_r    <= START;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign overflow = overflow_r;
    assign level    = level_r;

endmodule
